// File: rtl/seg_scan_decoder_pkg.sv
// Shared encode/decode constants for the four-digit multiplexed seven-segment display.
// The display driver imports this same package, so both directions share one source.
package seg_scan_decoder_pkg;

    // Active-low segment patterns on seg[6:0] (a = bit 0 ... g = bit 6)
    localparam logic [6:0] SEG_D0    = 7'h40;
    localparam logic [6:0] SEG_D1    = 7'h79;
    localparam logic [6:0] SEG_D2    = 7'h24;
    localparam logic [6:0] SEG_D3    = 7'h30;
    localparam logic [6:0] SEG_D4    = 7'h19;
    localparam logic [6:0] SEG_D5    = 7'h12;
    localparam logic [6:0] SEG_D6    = 7'h02;
    localparam logic [6:0] SEG_D7    = 7'h78;
    localparam logic [6:0] SEG_D8    = 7'h00;
    localparam logic [6:0] SEG_D9    = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low digit enables
    localparam logic [3:0] AN_SIGN = 4'b0111;
    localparam logic [3:0] AN_HUND = 4'b1011;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAP_H,
        ST_CAP_T,
        ST_CAP_O
    } scan_state_e;

    // Signed frame value from sign + BCD digits; the multiplies are shift-add.
    function automatic logic [10:0] frame_value(input logic       neg,
                                                input logic [3:0] h,
                                                input logic [3:0] t,
                                                input logic [3:0] o);
        logic [9:0] hw, tw, ow, mag;
        hw  = {6'b0, h};
        tw  = {6'b0, t};
        ow  = {6'b0, o};
        mag = (hw << 6) + (hw << 5) + (hw << 2) + (tw << 3) + (tw << 1) + ow;
        // Negating zero gives zero, so negative zero needs no special case
        return neg ? (11'd0 - {1'b0, mag}) : {1'b0, mag};
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg_to_digit.sv
// Combinational seven-segment pattern classifier: digit value plus
// digit / minus / blank flags. Any other pattern leaves all flags low.
module seg_to_digit
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       is_digit,
    output logic       is_minus,
    output logic       is_blank
);

    always_comb begin
        value    = 4'd0;
        is_digit = 1'b1;
        is_minus = 1'b0;
        is_blank = 1'b0;
        unique case (seg)
            SEG_D0:    value = 4'd0;
            SEG_D1:    value = 4'd1;
            SEG_D2:    value = 4'd2;
            SEG_D3:    value = 4'd3;
            SEG_D4:    value = 4'd4;
            SEG_D5:    value = 4'd5;
            SEG_D6:    value = 4'd6;
            SEG_D7:    value = 4'd7;
            SEG_D8:    value = 4'd8;
            SEG_D9:    value = 4'd9;
            SEG_MINUS: begin
                is_digit = 1'b0;
                is_minus = 1'b1;
            end
            SEG_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:   is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for the multiplexed seven-segment display: synchronizes the
// scanned buses, filters glitches, and reassembles sign + three BCD digits into a number.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  n_cnt,
    input  logic [7:0]  seg,
    output logic [10:0] number,
    output logic        frame_valid,
    output logic        locked,
    output logic        err
);

    // Counter saturates one past the accept point so a held pair is accepted only once
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [3:0]  n_cnt_s1_q, n_cnt_s2_q;
    logic [7:0]  seg_s1_q, seg_s2_q;
    logic [11:0] pair_prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        same, accept;

    scan_state_e state_q, state_d;
    logic        sign_q, sign_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d;
    logic [10:0] number_q, number_d;
    logic        frame_valid_q, frame_valid_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [10:0] prev_val_q, prev_val_d;
    logic        prev_vld_q, prev_vld_d;

    logic [3:0]  dec_value;
    logic        dec_is_digit, dec_is_minus, dec_is_blank;
    logic [3:0]  expect_an;
    logic [10:0] value;
    logic        raise_err;

    seg_to_digit u_seg_to_digit (
        .seg      (seg_s2_q[6:0]),
        .value    (dec_value),
        .is_digit (dec_is_digit),
        .is_minus (dec_is_minus),
        .is_blank (dec_is_blank)
    );

    always_comb begin
        same   = ({n_cnt_s2_q, seg_s2_q} == pair_prev_q);
        cnt_d  = 8'd0;
        if (same)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
        accept = same && (cnt_d == CNT_ACC);
    end

    always_comb begin
        unique case (state_q)
            ST_CAP_H: expect_an = AN_HUND;
            ST_CAP_T: expect_an = AN_TENS;
            ST_CAP_O: expect_an = AN_ONES;
            default:  expect_an = AN_NONE;
        endcase
        value = frame_value(sign_q, hund_q, tens_q, dec_value);
    end

    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        hund_d        = hund_q;
        tens_d        = tens_q;
        number_d      = number_q;
        frame_valid_d = 1'b0;
        locked_d      = locked_q;
        err_d         = 1'b0;
        prev_val_d    = prev_val_q;
        prev_vld_d    = prev_vld_q;
        raise_err     = 1'b0;

        if (accept && n_cnt_s2_q != AN_NONE) begin
            unique case (n_cnt_s2_q)
                AN_SIGN: begin
                    // A sign slot always (re)starts a frame, even mid-capture
                    if (dec_is_minus || dec_is_blank) begin
                        sign_d  = dec_is_minus;
                        state_d = ST_CAP_H;
                    end else begin
                        raise_err = 1'b1;
                    end
                end
                AN_HUND, AN_TENS, AN_ONES: begin
                    // In IDLE digit slots are ignored: capture may begin mid-scan
                    if (state_q != ST_IDLE) begin
                        if (n_cnt_s2_q != expect_an || !dec_is_digit) begin
                            raise_err = 1'b1;
                        end else begin
                            unique case (state_q)
                                ST_CAP_H: begin
                                    hund_d  = dec_value;
                                    state_d = ST_CAP_T;
                                end
                                ST_CAP_T: begin
                                    tens_d  = dec_value;
                                    state_d = ST_CAP_O;
                                end
                                default: begin
                                    number_d      = value;
                                    frame_valid_d = 1'b1;
                                    locked_d      = prev_vld_q && (value == prev_val_q);
                                    prev_val_d    = value;
                                    prev_vld_d    = 1'b1;
                                    state_d       = ST_IDLE;
                                end
                            endcase
                        end
                    end
                end
                default: raise_err = 1'b1;
            endcase
        end

        if (raise_err) begin
            err_d      = 1'b1;
            state_d    = ST_IDLE;
            locked_d   = 1'b0;
            prev_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_cnt_s1_q    <= AN_NONE;
            n_cnt_s2_q    <= AN_NONE;
            seg_s1_q      <= 8'hFF;
            seg_s2_q      <= 8'hFF;
            pair_prev_q   <= 12'hFFF;
            cnt_q         <= 8'd0;
            state_q       <= ST_IDLE;
            sign_q        <= 1'b0;
            hund_q        <= 4'd0;
            tens_q        <= 4'd0;
            number_q      <= 11'd0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            prev_val_q    <= 11'd0;
            prev_vld_q    <= 1'b0;
        end else begin
            n_cnt_s1_q    <= n_cnt;
            n_cnt_s2_q    <= n_cnt_s1_q;
            seg_s1_q      <= seg;
            seg_s2_q      <= seg_s1_q;
            pair_prev_q   <= {n_cnt_s2_q, seg_s2_q};
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            sign_q        <= sign_d;
            hund_q        <= hund_d;
            tens_q        <= tens_d;
            number_q      <= number_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            prev_val_q    <= prev_val_d;
            prev_vld_q    <= prev_vld_d;
        end
    end

    assign number      = number_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected frame/err events,
// a monitor pops and compares whenever frame_valid or err pulses.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  n_cnt;
    logic [7:0]  seg;
    logic [10:0] number;
    logic        frame_valid, locked, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [10:0] num;
        bit          lock;
    } exp_t;

    exp_t exp_q[$];

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .n_cnt       (n_cnt),
        .seg         (seg),
        .number      (number),
        .frame_valid (frame_valid),
        .locked      (locked),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid && err) chk("fv_err_overlap", 1, 0);
            if (frame_valid || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {frame_valid, err}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("event_is_err", err, e.is_err);
                    chk("number", number, e.num);
                    chk("locked", locked, e.lock);
                end
            end
        end
    end

    task automatic slot(input logic [3:0] an, input logic [7:0] sg, input int n);
        n_cnt = an;
        seg   = sg;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] s, input logic [7:0] h,
                         input logic [7:0] t, input logic [7:0] o);
        slot(4'b0111, s, 8);
        slot(4'b1011, h, 8);
        slot(4'b1101, t, 8);
        slot(4'b1110, o, 8);
    endtask

    function automatic exp_t fv(input logic [10:0] num, input bit lock);
        exp_t e;
        e.is_err = 1'b0;
        e.num    = num;
        e.lock   = lock;
        return e;
    endfunction

    function automatic exp_t er(input logic [10:0] num);
        exp_t e;
        e.is_err = 1'b1;
        e.num    = num;
        e.lock   = 1'b0;
        return e;
    endfunction

    initial begin
        int budget;
        rst   = 1'b1;
        n_cnt = 4'hF;
        seg   = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_number", number, 11'd0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // +123, then the same frame again locks
        exp_q.push_back(fv(11'h07B, 0));
        frame(8'hFF, 8'hF9, 8'hA4, 8'hB0);
        exp_q.push_back(fv(11'h07B, 1));
        frame(8'hFF, 8'hF9, 8'hA4, 8'hB0);

        // -42 then +42
        exp_q.push_back(fv(11'h7D6, 0));
        frame(8'hBF, 8'hC0, 8'h99, 8'hA4);
        exp_q.push_back(fv(11'h02A, 0));
        frame(8'hFF, 8'hC0, 8'h99, 8'hA4);
        exp_q.push_back(fv(11'h02A, 1));
        frame(8'hFF, 8'hC0, 8'h99, 8'hA4);

        // Blank tens slot: err, number holds 42, locked drops
        exp_q.push_back(er(11'h02A));
        frame(8'hFF, 8'hF9, 8'hFF, 8'hB0);

        // Previous value forgotten: same 42 again must not lock
        exp_q.push_back(fv(11'h02A, 0));
        frame(8'hFF, 8'hC0, 8'h99, 8'hA4);

        // Ones before tens
        exp_q.push_back(er(11'h02A));
        slot(4'b0111, 8'hFF, 8);
        slot(4'b1011, 8'hF9, 8);
        slot(4'b1110, 8'hB0, 8);

        // Short seg glitch inside the hundreds slot is filtered out
        exp_q.push_back(fv(11'h07B, 0));
        slot(4'b0111, 8'hFF, 8);
        slot(4'b1011, 8'hF9, 2);
        slot(4'b1011, 8'hC0, 2);
        slot(4'b1011, 8'hF9, 8);
        slot(4'b1101, 8'hA4, 8);
        slot(4'b1110, 8'hB0, 8);

        // Reset during tens capture
        slot(4'b0111, 8'hFF, 8);
        slot(4'b1011, 8'hF9, 8);
        slot(4'b1101, 8'hA4, 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_number", number, 11'd0);
        chk("midrst_locked", locked, 0);
        rst = 1'b0;
        slot(4'b1101, 8'hA4, 5);

        exp_q.push_back(fv(11'h3E7, 0));
        frame(8'hFF, 8'h90, 8'h90, 8'h90);
        // Negative zero
        exp_q.push_back(fv(11'h000, 0));
        frame(8'hBF, 8'hC0, 8'hC0, 8'hC0);

        slot(4'b1111, 8'hFF, 4);
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("queue_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
